// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command responder: command nibbles,
// default ACK/NACK bytes, FSM state encoding and the saturating error-count add.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_t;

   localparam logic [3:0] CMD_ON     = 4'h6;
   localparam logic [3:0] CMD_OFF    = 4'hD;
   localparam logic [3:0] CMD_TOGGLE = 4'h3;

   localparam logic [7:0] ACK_DEFAULT  = 8'h3C;
   localparam logic [7:0] NACK_DEFAULT = 8'hC3;

   // Several error sources can fire in one cycle, so the increment is up to 2.
   function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/hamming_7_4_decoder.sv
// Combinational Hamming(7,4) decoder, zero latency: bit0=p1, bit1=p2, bit2=d0,
// bit3=p4, bit4=d1, bit5=d2, bit6=d3. data is always the syndrome-corrected nibble.
module hamming_7_4_decoder (
   input  logic [6:0] code,
   output logic [3:0] data,
   output logic [2:0] syndrome,
   output logic       corrected
);

   logic [6:0] fixed;

   always_comb begin
      syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
      syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
      syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
      fixed = code;
      // A nonzero syndrome names the 1-based position of the flipped bit.
      for (int i = 0; i < 7; i++) begin
         if (syndrome == 3'(i + 1)) begin
            fixed[i] = ~code[i];
         end
      end
      data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
      corrected = |syndrome;
   end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes Hamming-protected command bytes from a UART, drives out_on and answers ACK/NACK;
// rx_done to start_tx is 3 clk. No backpressure: rx_done outside IDLE is dropped and counted.
// Single-bit correction is enabled by defining UART_CMD_HAMMING_CORRECT_EN.
module uart_cmd_responder
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] ACK_BYTE     = ACK_DEFAULT,
   parameter logic [7:0] NACK_BYTE    = NACK_DEFAULT,
   parameter int         BUSY_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       rx_parity_error,
   output logic [7:0] tx_data,
   output logic       start_tx,
   input  logic       tx_busy,
   output logic       out_on,
   output logic       cmd_strobe,
   output logic [7:0] err_count
);

   localparam int            TW         = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

`ifdef UART_CMD_HAMMING_CORRECT_EN
   localparam bit CORRECT_EN = 1'b1;
`else
   localparam bit CORRECT_EN = 1'b0;
`endif

   state_t        state, state_nxt;
   logic [7:0]    frame_q;
   logic          perr_q;
   logic [7:0]    resp_q;
   logic [TW-1:0] timer;

   logic [3:0]    nibble;
   logic [2:0]    syndrome;
   logic          corrected;
   logic          code_ok, cmd_ok;

   logic          load_frame, exec_ok, exec_nack, send, busy_seen, timeout_hit, overrun;
   logic [1:0]    err_inc;

   hamming_7_4_decoder u_dec (
      .code      (frame_q[6:0]),
      .data      (nibble),
      .syndrome  (syndrome),
      .corrected (corrected)
   );

   // Hamming(7,4) cannot tell a double error from a single one, so with correction on
   // every codeword is accepted as its nearest valid neighbour.
   assign code_ok = (syndrome == 3'd0) || (CORRECT_EN && corrected);
   assign cmd_ok  = !perr_q && code_ok &&
                    ((nibble == CMD_ON) || (nibble == CMD_OFF) || (nibble == CMD_TOGGLE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      load_frame  = 1'b0;
      exec_ok     = 1'b0;
      exec_nack   = 1'b0;
      send        = 1'b0;
      busy_seen   = 1'b0;
      timeout_hit = 1'b0;
      cmd_strobe  = 1'b0;
      overrun     = rx_done && (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (rx_done) begin
               load_frame = 1'b1;
               state_nxt  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_nxt = frame_q[7] ? ST_EXEC : ST_IDLE;
         end
         ST_EXEC: begin
            if (cmd_ok) begin
               exec_ok    = 1'b1;
               cmd_strobe = 1'b1;
            end else begin
               exec_nack  = 1'b1;
            end
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            send      = 1'b1;
            state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               busy_seen = 1'b1;
               state_nxt = ST_WAIT_DONE;
            end else if (timer == TIMER_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign err_inc = {1'b0, exec_nack} + {1'b0, timeout_hit} + {1'b0, overrun};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_q   <= 8'h00;
         perr_q    <= 1'b0;
         resp_q    <= 8'h00;
         out_on    <= 1'b0;
         tx_data   <= 8'h00;
         start_tx  <= 1'b0;
         timer     <= '0;
         err_count <= 8'h00;
      end else begin
         if (load_frame) begin
            frame_q <= rx_data;
            perr_q  <= rx_parity_error;
         end
         if (exec_ok) begin
            case (nibble)
               CMD_ON:  out_on <= 1'b1;
               CMD_OFF: out_on <= 1'b0;
               default: out_on <= ~out_on;
            endcase
         end
         if (exec_ok || exec_nack) begin
            resp_q <= exec_ok ? ACK_BYTE : NACK_BYTE;
         end
         // start_tx is held from SEND until uart_tx acknowledges with tx_busy or we give up.
         if (send) begin
            tx_data  <= resp_q;
            start_tx <= 1'b1;
         end else if (busy_seen || timeout_hit) begin
            start_tx <= 1'b0;
         end
         if (state == ST_WAIT_BUSY) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
         err_count <= sat_add(err_count, err_inc);
      end
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed scenarios plus randomized frames
// checked against a position-based Hamming reference model.
module tb_uart_cmd_responder;

   localparam int BUSY_TIMEOUT = 1024;
`ifdef UART_CMD_HAMMING_CORRECT_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       rx_parity_error = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] tx_data;
   logic       start_tx;
   logic       out_on;
   logic       cmd_strobe;
   logic [7:0] err_count;

   int         n_checks = 0;
   int         n_fail = 0;
   bit         m_out = 1'b0;
   logic [7:0] m_err = 8'h00;

   uart_cmd_responder dut (
      .clk             (clk),
      .reset           (reset),
      .rx_data         (rx_data),
      .rx_done         (rx_done),
      .rx_parity_error (rx_parity_error),
      .tx_data         (tx_data),
      .start_tx        (start_tx),
      .tx_busy         (tx_busy),
      .out_on          (out_on),
      .cmd_strobe      (cmd_strobe),
      .err_count       (err_count)
   );

   always #5 clk = ~clk;

   function automatic void model_bump(input int n);
      int s;
      s = int'(m_err) + n;
      m_err = (s > 255) ? 8'hFF : 8'(s);
   endfunction

   // Codeword position p (1..7) lives at bit p-1; parity bit at 2^k covers positions with bit k set.
   function automatic logic [6:0] enc(input logic [3:0] nib);
      logic [6:0] code;
      logic       par;
      code = 7'h00;
      code[2] = nib[0]; code[4] = nib[1]; code[5] = nib[2]; code[6] = nib[3];
      for (int p = 1; p <= 4; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos <= 7; pos++) begin
            if (((pos & p) != 0) && (pos != p)) par ^= code[pos-1];
         end
         code[p-1] = par;
      end
      return code;
   endfunction

   function automatic void model_step(input logic [7:0] d, input logic pe,
                                      output bit resp, output logic [7:0] b, output bit strobe);
      int         syn;
      logic [6:0] code;
      logic [3:0] nib;
      bit         bad;
      syn = 0;
      code = d[6:0];
      for (int pos = 1; pos <= 7; pos++) if (code[pos-1]) syn ^= pos;
      if (syn != 0 && CORR) code[syn-1] = ~code[syn-1];
      nib = {code[6], code[5], code[4], code[2]};
      resp = d[7];
      strobe = 1'b0;
      b = 8'h00;
      if (d[7]) begin
         bad = pe || (syn != 0 && !CORR) || !(nib == 4'h6 || nib == 4'hD || nib == 4'h3);
         if (bad) begin
            b = 8'hC3;
            model_bump(1);
         end else begin
            b = 8'h3C;
            strobe = 1'b1;
            if (nib == 4'h6) m_out = 1'b1;
            else if (nib == 4'hD) m_out = 1'b0;
            else m_out = !m_out;
         end
      end
   endfunction

   // Drives one frame and plays the uart_tx side; records what the DUT did.
   task automatic run_frame(input logic [7:0] d, input logic pe, input bit respond, input int n_inject,
                            output int lat, output bit strobe, output logic [7:0] txb,
                            output bit drop_ok, output int hold, output bit spurious);
      int inj;
      lat = -1; strobe = 1'b0; txb = 8'h00; drop_ok = 1'b1; hold = 0; spurious = 1'b0; inj = 0;
      @(posedge clk); #1;
      rx_data = d; rx_parity_error = pe; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0; rx_parity_error = 1'b0;
      for (int c = 1; c <= 12 && lat < 0; c++) begin
         @(posedge clk); #1;
         if (cmd_strobe) strobe = 1'b1;
         if (start_tx) lat = c;
      end
      if (lat > 0) begin
         txb = tx_data;
         hold = 1;
         if (respond) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
               if (!start_tx) drop_ok = 1'b0;
            end
            tx_busy = 1'b1;
            @(posedge clk); #1;
            if (start_tx) drop_ok = 1'b0;
            while (inj < n_inject) begin
               rx_data = 8'($urandom); rx_done = 1'b1;
               @(posedge clk); #1;
               rx_done = 1'b0; inj++;
               @(posedge clk); #1;
            end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 tx_busy = 1'b0;
         end else begin
            for (int c = 0; c < BUSY_TIMEOUT + 100 && start_tx; c++) begin
               if (inj < n_inject && (c % 2) == 0) begin
                  rx_data = 8'($urandom); rx_done = 1'b1; inj++;
               end
               @(posedge clk); #1;
               rx_done = 1'b0;
               if (start_tx) hold++;
            end
         end
      end
      repeat (4) begin
         @(posedge clk); #1;
         if (start_tx) spurious = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (out_on !== 1'b0) begin n_fail++; $display("FAIL reset_out_on: got %b want 0", out_on); end
      n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL reset_start_tx: got %b want 0", start_tx); end
      n_checks++; if (cmd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_strobe: got %b want 0", cmd_strobe); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count: got %h want 00", err_count); end
      @(posedge clk); #1 reset = 1'b1;
      m_out = 1'b0; m_err = 8'h00;
   endtask

   task automatic test_commands();
      int lat, hold; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb;
      logic [7:0] exp_tx, exp_err; bit exp_out, pre_out;
      run_frame(8'hB3, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hB3, 1'b0, r, eb, es);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL on_latency: got %0d want 3", lat); end
      n_checks++; if (strobe !== 1'b1) begin n_fail++; $display("FAIL on_strobe: got %b want 1", strobe); end
      n_checks++; if (txb !== 8'h3C) begin n_fail++; $display("FAIL on_tx_data: got %h want 3C", txb); end
      n_checks++; if (out_on !== 1'b1) begin n_fail++; $display("FAIL on_out_on: got %b want 1", out_on); end
      n_checks++; if (drop_ok !== 1'b1) begin n_fail++; $display("FAIL on_start_hold: got %b want 1", drop_ok); end
      n_checks++; if (spur !== 1'b0) begin n_fail++; $display("FAIL on_spurious_tx: got %b want 0", spur); end

      run_frame(8'h9E, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'h9E, 1'b0, r, eb, es);
      n_checks++; if (out_on !== 1'b0) begin n_fail++; $display("FAIL toggle_out_on: got %b want 0", out_on); end
      n_checks++; if (txb !== 8'h3C) begin n_fail++; $display("FAIL toggle_tx_data: got %h want 3C", txb); end

      run_frame(8'hE6, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hE6, 1'b0, r, eb, es);
      n_checks++; if (out_on !== 1'b0) begin n_fail++; $display("FAIL off_out_on: got %b want 0", out_on); end
      n_checks++; if (txb !== 8'h3C) begin n_fail++; $display("FAIL off_tx_data: got %h want 3C", txb); end

`ifdef UART_CMD_HAMMING_CORRECT_EN
      exp_out = 1'b1; exp_tx = 8'h3C; exp_err = 8'h00;
`else
      exp_out = 1'b0; exp_tx = 8'hC3; exp_err = 8'h01;
`endif
      run_frame(8'hA3, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hA3, 1'b0, r, eb, es);
      n_checks++; if (out_on !== exp_out) begin n_fail++; $display("FAIL flip_out_on: got %b want %b", out_on, exp_out); end
      n_checks++; if (txb !== exp_tx) begin n_fail++; $display("FAIL flip_tx_data: got %h want %h", txb, exp_tx); end
      n_checks++; if (err_count !== exp_err) begin n_fail++; $display("FAIL flip_err_count: got %h want %h", err_count, exp_err); end

      pre_out = m_out;
      run_frame(8'hB3, 1'b1, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hB3, 1'b1, r, eb, es);
      n_checks++; if (txb !== 8'hC3) begin n_fail++; $display("FAIL parity_tx_data: got %h want C3", txb); end
      n_checks++; if (out_on !== pre_out) begin n_fail++; $display("FAIL parity_out_on: got %b want %b", out_on, pre_out); end
      n_checks++; if (err_count !== exp_err + 8'd1) begin n_fail++; $display("FAIL parity_err_count: got %h want %h", err_count, exp_err + 8'd1); end
      n_checks++; if (strobe !== 1'b0) begin n_fail++; $display("FAIL parity_strobe: got %b want 0", strobe); end
   endtask

   task automatic test_ignore();
      int lat, hold; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb;
      run_frame(8'h33, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'h33, 1'b0, r, eb, es);
      n_checks++; if (lat !== -1) begin n_fail++; $display("FAIL ignore_no_tx: got latency %0d want none", lat); end
      n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL ignore_err_count: got %h want %h", err_count, m_err); end
      n_checks++; if (out_on !== m_out) begin n_fail++; $display("FAIL ignore_out_on: got %b want %b", out_on, m_out); end
   endtask

   task automatic test_timeout();
      int lat, hold; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb;
      run_frame(8'hB3, 1'b0, 1'b0, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hB3, 1'b0, r, eb, es);
      model_bump(1);
      n_checks++; if (hold !== BUSY_TIMEOUT) begin n_fail++; $display("FAIL timeout_hold: got %0d cycles want %0d", hold, BUSY_TIMEOUT); end
      n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL timeout_err_count: got %h want %h", err_count, m_err); end
      n_checks++; if (spur !== 1'b0) begin n_fail++; $display("FAIL timeout_spurious_tx: got %b want 0", spur); end
      run_frame(8'h9E, 1'b0, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'h9E, 1'b0, r, eb, es);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL timeout_then_idle: got latency %0d want 3", lat); end
      n_checks++; if (out_on !== m_out) begin n_fail++; $display("FAIL timeout_then_out_on: got %b want %b", out_on, m_out); end
   endtask

   task automatic test_back_to_back();
      int lat, hold; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb;
      run_frame(8'h9E, 1'b0, 1'b1, 1, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'h9E, 1'b0, r, eb, es);
      model_bump(1);
      n_checks++; if (txb !== 8'h3C) begin n_fail++; $display("FAIL overrun_tx_data: got %h want 3C", txb); end
      n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL overrun_err_count: got %h want %h", err_count, m_err); end
      n_checks++; if (out_on !== m_out) begin n_fail++; $display("FAIL overrun_out_on: got %b want %b", out_on, m_out); end
      n_checks++; if (spur !== 1'b0) begin n_fail++; $display("FAIL overrun_second_tx: got %b want 0", spur); end
   endtask

   task automatic test_random();
      int lat, hold, k, sel; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb, d;
      logic [3:0] nib; logic [6:0] code; logic pe;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 3);
         nib = (sel == 0) ? 4'h6 : (sel == 1) ? 4'hD : (sel == 2) ? 4'h3 : 4'($urandom);
         code = enc(nib);
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 6);
            code[k] = ~code[k];
         end
         d = {($urandom_range(0, 9) != 0), code};
         pe = ($urandom_range(0, 9) == 0);
         run_frame(d, pe, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
         model_step(d, pe, r, eb, es);
         n_checks++; if (lat !== (r ? 3 : -1)) begin n_fail++; $display("FAIL rand_latency[%0d] d=%h: got %0d want %0d", i, d, lat, r ? 3 : -1); end
         n_checks++; if (txb !== eb) begin n_fail++; $display("FAIL rand_tx_data[%0d] d=%h pe=%b: got %h want %h", i, d, pe, txb, eb); end
         n_checks++; if (strobe !== es) begin n_fail++; $display("FAIL rand_strobe[%0d] d=%h: got %b want %b", i, d, strobe, es); end
         n_checks++; if (out_on !== m_out) begin n_fail++; $display("FAIL rand_out_on[%0d] d=%h: got %b want %b", i, d, out_on, m_out); end
         n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL rand_err_count[%0d] d=%h: got %h want %h", i, d, err_count, m_err); end
      end
   endtask

   task automatic test_saturation();
      int lat, hold; bit strobe, drop_ok, spur, r, es; logic [7:0] txb, eb;
      run_frame(8'hE6, 1'b0, 1'b0, 300, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hE6, 1'b0, r, eb, es);
      model_bump(301);
      n_checks++; if (err_count !== m_err) begin n_fail++; $display("FAIL sat_err_count: got %h want %h", err_count, m_err); end
      run_frame(8'hB3, 1'b1, 1'b1, 0, lat, strobe, txb, drop_ok, hold, spur);
      model_step(8'hB3, 1'b1, r, eb, es);
      n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_no_wrap: got %h want FF", err_count); end
      n_checks++; if (txb !== 8'hC3) begin n_fail++; $display("FAIL sat_nack: got %h want C3", txb); end
   endtask

   task automatic test_reset_mid_tx();
      bit seen, spur;
      seen = 1'b0; spur = 1'b0;
      @(posedge clk); #1;
      rx_data = 8'hB3; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         @(posedge clk); #1;
         if (start_tx) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midreset_no_start: got %b want 1", seen); end
      #3 reset = 1'b0;
      #1;
      n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL midreset_start_tx: got %b want 0", start_tx); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_tx_data: got %h want 00", tx_data); end
      n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL midreset_err_count: got %h want 00", err_count); end
      n_checks++; if (out_on !== 1'b0) begin n_fail++; $display("FAIL midreset_out_on: got %b want 0", out_on); end
      @(posedge clk); #1 reset = 1'b1;
      tx_busy = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (start_tx) spur = 1'b1;
      end
      tx_busy = 1'b0;
      n_checks++; if (spur !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got %b want 0", spur); end
      m_out = 1'b0; m_err = 8'h00;
   endtask

   initial begin
      test_reset();
      test_commands();
      test_ignore();
      test_timeout();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_mid_tx();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter ACK_BYTE, default 8'h3C, byte sent after a valid command.
REQ-002 SHALL have parameter NACK_BYTE, default 8'hC3, byte sent after a rejected frame.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 1024, the number of clk cycles to wait for tx_busy to rise.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, 48 MHz.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8 bits: byte from the uart_rx instance.
REQ-007 SHALL have port rx_done, input, 1 bit: one-cycle strobe marking rx_data valid.
REQ-008 SHALL have port rx_parity_error, input, 1 bit: parity flag, valid with rx_done.
REQ-009 SHALL have port tx_data, output, 8 bits: response byte to uart_tx.
REQ-010 SHALL have port start_tx, output, 1 bit: transmit request to uart_tx.
REQ-011 SHALL have port tx_busy, input, 1 bit: busy flag from uart_tx.
REQ-012 SHALL have port out_on, output, 1 bit: commanded output state, 1 = on.
REQ-013 SHALL have port cmd_strobe, output, 1 bit: one-cycle pulse when a command executes.
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of rejected or dropped frames.

Function
REQ-015 SHALL decode each frame as follows: bit7 = command marker; bits6:0 = Hamming(7,4) codeword.
- bit0 = p1, bit1 = p2, bit2 = d0, bit3 = p4, bit4 = d1, bit5 = d2, bit6 = d3.
- p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
- syndrome = {s4, s2, s1}; a nonzero syndrome indexes the erroneous bit position, 1 to 7.
REQ-016 SHALL implement the states IDLE, DECODE, EXEC, SEND, WAIT_BUSY and WAIT_DONE.
- IDLE -> DECODE on rx_done.
- DECODE -> EXEC -> SEND.
- SEND -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE on tx_busy = 1.
- WAIT_DONE -> IDLE on tx_busy = 0.
REQ-017 SHALL ignore a frame with marker = 0: no response is sent, the state returns to IDLE, and err_count is unchanged.
REQ-018 SHALL reject a frame with rx_parity_error = 1, or an uncorrectable codeword, by sending NACK_BYTE and incrementing err_count.
REQ-019 SHALL execute these data nibbles:
- 4'h6: out_on <= 1.
- 4'hD: out_on <= 0.
- 4'h3: out_on <= ~out_on.
- any other nibble: reject as in REQ-018.
REQ-020 SHALL, on a valid command, update out_on and pulse cmd_strobe in EXEC, then send ACK_BYTE.
REQ-021 SHALL drive tx_data and set start_tx = 1 in SEND, hold start_tx until tx_busy is seen high, then clear it.
REQ-022 SHALL, if tx_busy has not risen within BUSY_TIMEOUT cycles of WAIT_BUSY:
- clear start_tx;
- increment err_count;
- return to IDLE.
REQ-023 SHALL drop an rx_done that arrives in any state other than IDLE and increment err_count (overrun).
REQ-024 SHALL saturate err_count at 8'hFF with no wrap-around.
REQ-025 SHALL give a latency from rx_done to start_tx rising of exactly 3 clk cycles.

Reset
REQ-026 SHALL, while reset = 0, force:
- state = IDLE;
- out_on = 0;
- start_tx = 0, cmd_strobe = 0;
- tx_data = 8'h00, err_count = 0;
- the timeout counter = 0.
REQ-027 SHALL, on reset asserted mid-transmission, clear start_tx immediately and discard the pending response.

Configuration
REQ-028 SHALL, with macro UART_CMD_HAMMING_CORRECT_EN defined, correct a single-bit codeword error by flipping the bit indexed by the syndrome and then execute the corrected command.
REQ-029 SHALL, without UART_CMD_HAMMING_CORRECT_EN, treat any nonzero syndrome as uncorrectable.

Structure
REQ-030 SHALL place these items in shared package uart_cmd_pkg:
- command nibble constants CMD_ON = 4'h6, CMD_OFF = 4'hD, CMD_TOGGLE = 4'h3;
- the ACK/NACK default values;
- the state encoding.
REQ-031 SHALL instantiate one combinational sub-module, hamming_7_4_decoder (inputs: 7-bit codeword; outputs: data nibble, syndrome, corrected flag).

Verification
REQ-032 SHALL cover: rx_data = 8'hB3, rx_done -> out_on = 1, cmd_strobe pulse, tx_data = 8'h3C, start_tx 3 cycles after rx_done.
REQ-033 SHALL cover: with out_on = 1, rx_data = 8'h9E -> out_on = 0, ACK 8'h3C; then rx_data = 8'hE6 -> out_on stays 0, ACK 8'h3C.
REQ-034 SHALL cover: rx_data = 8'hA3 (bit4 flipped) -> with the macro, out_on = 1 and ACK 8'h3C; without it, NACK 8'hC3 and err_count = 1.
REQ-035 SHALL cover: rx_data = 8'hB3 with rx_parity_error = 1 -> NACK 8'hC3, out_on unchanged, err_count + 1.
REQ-036 SHALL cover: tx_busy held 0 after SEND -> start_tx clears after 1024 cycles, err_count + 1, state IDLE.
REQ-037 SHALL cover: a second rx_done during WAIT_DONE -> frame dropped, err_count + 1, ACK for the first frame completes normally.
